mario_anim_ctrl: RTL and testbench

MARIO_ANIM_CTRL -- requirements
Module: mario_anim_ctrl

---
 rtl/mario_anim_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mario_anim_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mario_anim_ctrl.sv
// Sprite animation controller: walk-cycle frames, facing, invincibility blink and grow/shrink flash.
// Latency: all state registered on clk; id/max_w/max_h are combinational from registers.
// Backpressure: none; tick inputs are sampled and only their rising edges advance the counters.
module mario_anim_ctrl #(
    parameter int WALK_FRAMES = 3,
    parameter int HERO_TICKS  = 64,
    parameter int MORPH_TICKS = 8,
    parameter int SMALL_BASE  = 26,
    parameter int BIG_BASE    = 15,
    parameter int NULL_ID     = 63,
    parameter int ID_W        = 6,
    parameter int SMALL_W     = 40,
    parameter int SMALL_H     = 42,
    parameter int BIG_W       = 45,
    parameter int BIG_H       = 78
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            walk_tick,
    input  logic            hero_tick,
    input  logic            left,
    input  logic            right,
    input  logic            jump,
    input  logic            level,
    input  logic            hero_start,
    output logic [ID_W-1:0] id,
    output logic [1:0]      frame,
    output logic            orient,
    output logic            walk,
    output logic            hero_active,
    output logic            morphing,
    output logic            shown_level,
    output logic [10:0]     max_w,
    output logic [10:0]     max_h
);

    localparam logic [1:0]      LAST_FRAME = 2'(WALK_FRAMES - 1);
    localparam logic [9:0]      HERO_LOAD  = 10'(HERO_TICKS);
    localparam logic [7:0]      MORPH_LOAD = 8'(MORPH_TICKS);
    localparam logic [ID_W-1:0] SMALL_ID   = ID_W'(SMALL_BASE);
    localparam logic [ID_W-1:0] BIG_ID     = ID_W'(BIG_BASE);
    localparam logic [ID_W-1:0] HIDDEN_ID  = ID_W'(NULL_ID);

    logic       walk_tick_q;
    logic       hero_tick_q;
    logic       walk_edge;
    logic       hero_edge;
    logic       dir_down;
    logic [1:0] frame_step;
    logic [9:0] hero_cnt;
    logic       blink;
    logic [7:0] morph_cnt;
    logic       target_q;

    // Previous tick samples; loading them during reset keeps a high tick from
    // looking like a fresh edge on the first cycle afterwards.
    always_ff @(posedge clk) begin
        walk_tick_q <= walk_tick;
        hero_tick_q <= hero_tick;
    end

    assign walk_edge = walk_tick & ~walk_tick_q;
    assign hero_edge = hero_tick & ~hero_tick_q;

    // Facing follows a single pressed direction and holds when both or none are pressed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            orient <= 1'b0;
            walk   <= 1'b0;
        end else begin
            if (left && !right) begin
                orient <= 1'b1;
            end else if (right && !left) begin
                orient <= 1'b0;
            end
            walk <= left | right;
        end
    end

    // Candidate frame for the next step in the current ping-pong direction.
    always_comb begin
        frame_step = frame + 2'd1;
        if (dir_down) begin
            frame_step = frame - 2'd1;
        end
    end

    // Ping-pong walk cycle 0..LAST_FRAME..0; standing resets it, jumping freezes it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame    <= 2'd0;
            dir_down <= 1'b0;
        end else if (!walk) begin
            frame    <= 2'd0;
            dir_down <= 1'b0;
        end else if (walk_edge && !jump) begin
            frame <= frame_step;
            if (frame_step == LAST_FRAME) begin
                dir_down <= 1'b1;
            end else if (frame_step == 2'd0) begin
                dir_down <= 1'b0;
            end
        end
    end

    // Invincibility countdown with blink; a start pulse takes priority over a same-cycle tick.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hero_cnt    <= 10'd0;
            hero_active <= 1'b0;
            blink       <= 1'b0;
        end else if (hero_start) begin
            hero_cnt    <= HERO_LOAD;
            hero_active <= 1'b1;
            blink       <= 1'b0;
        end else if (hero_edge && hero_active) begin
            hero_cnt <= hero_cnt - 10'd1;
            if (hero_cnt == 10'd1) begin
                hero_active <= 1'b0;
                blink       <= 1'b0;
            end else begin
                blink <= ~blink;
            end
        end
    end

    // Grow/shrink flash: a new target restarts the flash without disturbing the shown size;
    // the final tick lands on the target regardless of toggle parity.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shown_level <= level;
            target_q    <= level;
            morphing    <= 1'b0;
            morph_cnt   <= 8'd0;
        end else if (level != target_q) begin
            target_q  <= level;
            morph_cnt <= MORPH_LOAD;
            morphing  <= 1'b1;
        end else if (morphing && hero_edge) begin
            morph_cnt <= morph_cnt - 8'd1;
            if (morph_cnt == 8'd1) begin
                shown_level <= target_q;
                morphing    <= 1'b0;
            end else begin
                shown_level <= ~shown_level;
            end
        end
    end

    // Sprite id: hidden during blink, else size base + two ids per frame, odd id faces right.
    always_comb begin
        logic [ID_W-1:0] base_id;
        logic [1:0]      f_eff;
        logic [ID_W-1:0] frame_off;
        logic [ID_W-1:0] face_off;
        base_id   = shown_level ? BIG_ID : SMALL_ID;
        f_eff     = walk ? frame : 2'd0;
        frame_off = {{(ID_W-3){1'b0}}, f_eff, 1'b0};
        face_off  = {{(ID_W-1){1'b0}}, ~orient};
        id        = base_id + frame_off + face_off;
        if (hero_active && blink) begin
            id = HIDDEN_ID;
        end
    end

    // Bounding box tracks the size currently on screen, including mid-flash.
    always_comb begin
        max_w = 11'(SMALL_W);
        max_h = 11'(SMALL_H);
        if (shown_level) begin
            max_w = 11'(BIG_W);
            max_h = 11'(BIG_H);
        end
    end

endmodule

// File: tb/tb_mario_anim_ctrl.sv
module tb_mario_anim_ctrl;

    localparam int WF = 3;
    localparam int HT = 64;
    localparam int MT = 8;

    logic        clk = 1'b0;
    logic        rstn, walk_tick, hero_tick, left, right, jump, level, hero_start;
    logic [5:0]  id;
    logic [1:0]  frame;
    logic        orient, walk, hero_active, morphing, shown_level;
    logic [10:0] max_w, max_h;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit m_wq, m_hq, m_orient, m_walk, m_target, m_shown;
    int m_pos, m_hrem, m_mrem;

    int exp32[5] = '{29, 31, 29, 27, 29};
    int exp32f[5] = '{1, 2, 1, 0, 1};

    always #5 clk = ~clk;

    mario_anim_ctrl #(.WALK_FRAMES(WF), .HERO_TICKS(HT), .MORPH_TICKS(MT)) dut (
        .clk(clk), .rstn(rstn), .walk_tick(walk_tick), .hero_tick(hero_tick),
        .left(left), .right(right), .jump(jump), .level(level), .hero_start(hero_start),
        .id(id), .frame(frame), .orient(orient), .walk(walk), .hero_active(hero_active),
        .morphing(morphing), .shown_level(shown_level), .max_w(max_w), .max_h(max_h)
    );

    function automatic int m_frame();
        int p = 2 * (WF - 1);
        return (m_pos < WF) ? m_pos : p - m_pos;
    endfunction

    function automatic int m_id();
        int base;
        if (m_hrem > 0 && ((HT - m_hrem) % 2 == 1)) return 63;
        base = m_shown ? 15 : 26;
        return base + 2 * (m_walk ? m_frame() : 0) + (m_orient ? 0 : 1);
    endfunction

    task automatic model_step();
        bit we, he;
        int p = 2 * (WF - 1);
        if (!rstn) begin
            m_wq = walk_tick; m_hq = hero_tick;
            m_orient = 0; m_walk = 0; m_pos = 0; m_hrem = 0; m_mrem = 0;
            m_target = level; m_shown = level;
            return;
        end
        we = walk_tick && !m_wq;
        he = hero_tick && !m_hq;
        m_wq = walk_tick;
        m_hq = hero_tick;
        if (!m_walk) m_pos = 0;
        else if (we && !jump) m_pos = (m_pos + 1) % p;
        if (left && !right) m_orient = 1;
        else if (right && !left) m_orient = 0;
        m_walk = left || right;
        if (hero_start) m_hrem = HT;
        else if (he && m_hrem > 0) m_hrem--;
        if (level != m_target) begin
            m_target = level;
            m_mrem = MT;
        end else if (he && m_mrem > 0) begin
            m_mrem--;
            m_shown = (m_mrem == 0) ? m_target : !m_shown;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        chk("id", 32'(id), m_id());
        chk("frame", 32'(frame), m_frame());
        chk("orient", 32'(orient), 32'(m_orient));
        chk("walk", 32'(walk), 32'(m_walk));
        chk("hero_active", 32'(hero_active), (m_hrem > 0) ? 1 : 0);
        chk("morphing", 32'(morphing), (m_mrem > 0) ? 1 : 0);
        chk("shown_level", 32'(shown_level), 32'(m_shown));
        chk("max_w", 32'(max_w), m_shown ? 45 : 40);
        chk("max_h", 32'(max_h), m_shown ? 78 : 42);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (chk_en) compare_all();
    endtask

    task automatic do_reset(input bit lvl);
        rstn = 1'b0;
        level = lvl;
        cyc();
        chk_en = 1'b1;
        cyc();
        rstn = 1'b1;
    endtask

    task automatic wtick();
        walk_tick = 1'b1; cyc();
        walk_tick = 1'b0; cyc();
    endtask

    task automatic htick();
        hero_tick = 1'b1; cyc();
        hero_tick = 1'b0; cyc();
    endtask

    task automatic pulse_hero();
        hero_start = 1'b1; cyc();
        hero_start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; walk_tick = 1'b0; hero_tick = 1'b0; left = 1'b0; right = 1'b0;
        jump = 1'b0; level = 1'b0; hero_start = 1'b0;

        // reset state, small level
        do_reset(1'b0);
        chk("rst_id", 32'(id), 27);
        chk("rst_max_w", 32'(max_w), 40);
        chk("rst_max_h", 32'(max_h), 42);
        chk("rst_hero", 32'(hero_active), 0);

        // walking right, small: ping-pong through frames
        right = 1'b1; cyc();
        for (int i = 0; i < 5; i++) begin
            wtick();
            chk("walk_right_id", 32'(id), exp32[i]);
            chk("walk_right_frame", 32'(frame), exp32f[i]);
        end
        right = 1'b0; cyc(); cyc();
        chk("stand_frame", 32'(frame), 0);

        // walking left, big, then jump freezes the frame
        do_reset(1'b1);
        left = 1'b1; cyc();
        chk("walk_left_id0", 32'(id), 15);
        wtick(); chk("walk_left_id1", 32'(id), 17);
        wtick(); chk("walk_left_id2", 32'(id), 19);
        jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wtick(); chk("jump_hold_id", 32'(id), 19);
        end
        jump = 1'b0; left = 1'b0; cyc();

        // full invincibility run
        do_reset(1'b0);
        pulse_hero();
        for (int k = 1; k <= HT; k++) begin
            htick();
            chk("hero_blink_id", 32'(id), (k % 2 == 1) ? 63 : 27);
        end
        chk("hero_done", 32'(hero_active), 0);

        // restart mid-run extends invincibility
        pulse_hero();
        for (int k = 0; k < 30; k++) htick();
        pulse_hero();
        for (int k = 0; k < HT - 1; k++) begin
            htick(); chk("hero_restart_active", 32'(hero_active), 1);
        end
        htick();
        chk("hero_restart_done", 32'(hero_active), 0);

        // grow while idle
        level = 1'b1; cyc();
        chk("grow_morphing", 32'(morphing), 1);
        chk("grow_shown0", 32'(shown_level), 0);
        for (int k = 1; k < MT; k++) begin
            htick(); chk("grow_toggle", 32'(shown_level), k % 2);
        end
        htick();
        chk("grow_final", 32'(shown_level), 1);
        chk("grow_max_h", 32'(max_h), 78);
        chk("grow_done", 32'(morphing), 0);

        // retarget mid-flash
        do_reset(1'b0);
        level = 1'b1; cyc();
        for (int k = 0; k < 3; k++) htick();
        chk("retarget_shown", 32'(shown_level), 1);
        level = 1'b0; cyc();
        chk("retarget_keep", 32'(shown_level), 1);
        chk("retarget_morph", 32'(morphing), 1);
        for (int k = 0; k < MT - 1; k++) htick();
        chk("retarget_still", 32'(morphing), 1);
        htick();
        chk("retarget_final", 32'(shown_level), 0);
        chk("retarget_done", 32'(morphing), 0);

        // reset aborts invincibility
        pulse_hero();
        for (int k = 0; k < 5; k++) htick();
        rstn = 1'b0; cyc(); rstn = 1'b1;
        chk("abort_hero", 32'(hero_active), 0);
        chk("abort_id", 32'(id), 27);

        // randomized traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) left = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) right = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) jump = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) walk_tick = ~walk_tick;
            if ($urandom_range(0, 2) == 0) hero_tick = ~hero_tick;
            hero_start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 149) == 0) level = ~level;
            rstn = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
